// File: rtl/rf_write_arbiter_32d_pkg.sv
// Shared register-file definitions for the 32-entry FPGA register RAM and its writers.
// Entry 0 is hardwired zero, so writes aimed at it must never reach the RAM.
package rf_write_arbiter_32d_pkg;

    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = 5;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    function automatic logic rf_writable(input rf_addr_t addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_32d_arb.sv
// Round-robin arbiter with a rotating priority pointer.
// Priority starts at ptr; after a grant to i the pointer moves to i+1.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    int            idx;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + PW'(1);
        end
    end

endmodule

// File: rtl/rf_write_arbiter_32d.sv
// Funnels register-file write requests into the single RAM write port through
// one registered write stage, which is also exported as a forwarding bypass.
module rf_write_arbiter_32d
    import rf_write_arbiter_32d_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              hold,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [NREQ-1:0][RF_ADDR_W-1:0]    req_addr,
    input  logic [NREQ-1:0][WIDTH-1:0]        req_data,
    output logic                              ram_wea,
    output logic [RF_ADDR_W-1:0]              ram_addrw,
    output logic [WIDTH-1:0]                  ram_din,
    output logic                              byp_valid,
    output logic [RF_ADDR_W-1:0]              byp_addr,
    output logic [WIDTH-1:0]                  byp_data
);

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [WIDTH-1:0]     data;
    } wreq_t;

    logic [NREQ-1:0] grant;
    logic            granted;
    logic            do_write;
    wreq_t           sel;
    wreq_t           stage_q;
    logic            wea_q;

    // Nothing is accepted while held or while reset is asserted.
    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (!hold && !rst),
        .grant (grant)
    );

    assign req_ready = grant;
    assign granted   = |grant;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.addr = req_addr[i];
                sel.data = req_data[i];
            end
        end
    end

    assign do_write = granted && rf_writable(sel.addr);

    // Address/data hold their last written value when idle so the bypass stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wea_q   <= 1'b0;
            stage_q <= '0;
        end else begin
            wea_q <= do_write;
            if (do_write) begin
                stage_q <= sel;
            end
        end
    end

    assign ram_wea   = wea_q;
    assign ram_addrw = stage_q.addr;
    assign ram_din   = stage_q.data;
    assign byp_valid = wea_q;
    assign byp_addr  = stage_q.addr;
    assign byp_data  = stage_q.data;

endmodule

// File: tb/tb_rf_write_arbiter_32d.sv
// Directed bench for rf_write_arbiter_32d with a small behavioural RAM on the write port.
module tb_rf_write_arbiter_32d;

    logic                 clk;
    logic                 rst;
    logic                 hold;
    logic [3:0]           req_valid;
    logic [3:0]           req_ready;
    logic [3:0][4:0]      req_addr;
    logic [3:0][31:0]     req_data;
    logic                 ram_wea;
    logic [4:0]           ram_addrw;
    logic [31:0]          ram_din;
    logic                 byp_valid;
    logic [4:0]           byp_addr;
    logic [31:0]          byp_data;

    logic [31:0] mem [32];
    int checkCount = 0;
    int failCount  = 0;

    rf_write_arbiter_32d #(.WIDTH(32), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ram_wea   (ram_wea),
        .ram_addrw (ram_addrw),
        .ram_din   (ram_din),
        .byp_valid (byp_valid),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register RAM stand-in: entry 0 never changes.
    always @(posedge clk) begin
        if (ram_wea && ram_addrw != 5'd0) mem[ram_addrw] <= ram_din;
    end

    task automatic applyStimulus(input logic r, input logic h, input logic [3:0] v);
        @(negedge clk);
        rst = r;
        hold = h;
        req_valid = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rst = 1'b1;
        hold = 1'b0;
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 5'(i + 1);
            req_data[i] = 32'h100 + 32'(i);
        end

        tick();
        checkOutput("reset_wea",   ram_wea,   1'b0);
        checkOutput("reset_addrw", ram_addrw, 5'd0);
        checkOutput("reset_din",   ram_din,   32'h0);
        checkOutput("reset_byp",   {byp_valid, byp_addr, byp_data}, 38'h0);
        checkOutput("reset_ready", req_ready, 4'b0000);

        $display("[TB] round-robin with all four requesters valid");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 4'b1111);
            checkOutput("rr_ready", req_ready, 4'b0001 << (k % 4));
            tick();
            checkOutput("rr_wea",   ram_wea,   1'b1);
            checkOutput("rr_addrw", ram_addrw, 5'((k % 4) + 1));
            checkOutput("rr_din",   ram_din,   32'h100 + 32'(k % 4));
        end

        $display("[TB] reset asserted mid-stream");
        applyStimulus(1'b1, 1'b0, 4'b1111);
        checkOutput("midrst_wea_async", ram_wea,   1'b0);
        checkOutput("midrst_ready",     req_ready, 4'b0000);
        tick();
        checkOutput("midrst_wea_edge",  ram_wea,   1'b0);
        checkOutput("midrst_byp_valid", byp_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("postrst_ready", req_ready, 4'b0001);
        tick();
        checkOutput("postrst_addrw", ram_addrw, 5'd1);

        $display("[TB] hold with requesters 1 and 3 valid");
        req_addr[1] = 5'd9;  req_data[1] = 32'h99;
        req_addr[3] = 5'd11; req_data[3] = 32'hBB;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 4'b1010);
            checkOutput("hold_ready", req_ready, 4'b0000);
            tick();
            checkOutput("hold_wea", ram_wea, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 4'b1010);
        checkOutput("release_ready1", req_ready, 4'b0010);
        tick();
        checkOutput("release_stage1", {ram_wea, ram_addrw, ram_din}, {1'b1, 5'd9, 32'h99});
        applyStimulus(1'b0, 1'b0, 4'b1000);
        checkOutput("release_ready3", req_ready, 4'b1000);
        tick();
        checkOutput("release_stage3", {ram_wea, ram_addrw, ram_din}, {1'b1, 5'd11, 32'hBB});

        $display("[TB] sparse single requester");
        req_addr[2] = 5'd7; req_data[2] = 32'hDEADBEEF;
        applyStimulus(1'b0, 1'b0, 4'b0100);
        checkOutput("sparse_ready", req_ready, 4'b0100);
        tick();
        checkOutput("sparse_stage", {ram_wea, ram_addrw, ram_din}, {1'b1, 5'd7, 32'hDEADBEEF});
        checkOutput("sparse_byp",   {byp_valid, byp_addr, byp_data}, {1'b1, 5'd7, 32'hDEADBEEF});
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("sparse_idle_ready", req_ready, 4'b0000);
        tick();
        checkOutput("sparse_idle_wea", ram_wea, 1'b0);
        checkOutput("sparse_hold_din", ram_din, 32'hDEADBEEF);
        checkOutput("sparse_ram",      mem[7],  32'hDEADBEEF);

        $display("[TB] write to entry 0");
        req_addr[1] = 5'd0; req_data[1] = 32'h1234;
        applyStimulus(1'b0, 1'b0, 4'b0010);
        checkOutput("addr0_ready", req_ready, 4'b0010);
        tick();
        checkOutput("addr0_wea", ram_wea, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        tick();
        checkOutput("addr0_ram", mem[0], 32'h0);

        $display("[TB] same address in consecutive cycles");
        req_addr[0] = 5'd5; req_data[0] = 32'hA;
        req_addr[1] = 5'd5; req_data[1] = 32'hB;
        applyStimulus(1'b0, 1'b0, 4'b0011);
        checkOutput("same_ready0", req_ready, 4'b0001);
        tick();
        checkOutput("same_byp_a", {byp_valid, byp_addr, byp_data}, {1'b1, 5'd5, 32'hA});
        applyStimulus(1'b0, 1'b0, 4'b0010);
        checkOutput("same_ready1", req_ready, 4'b0010);
        tick();
        checkOutput("same_byp_b", {byp_valid, byp_addr, byp_data}, {1'b1, 5'd5, 32'hB});
        applyStimulus(1'b0, 1'b0, 4'b0000);
        tick();
        checkOutput("same_ram", mem[5], 32'hB);

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
